// File: rtl/fft_pkg.sv
// Shared constants, read-FSM encoding and index helper
// for the FFT frame packer.
package fft_pkg;

  localparam int N_BINS = 16;
  localparam int LOG2N  = 4;
  localparam int W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank.sv
// One frame bank: N_BINS x W register file with a
// single write port and a full packed read bus.
module fft_bank
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [LOG2N-1:0]    addr,
  input  logic [W-1:0]        wdata,
  output logic [N_BINS*W-1:0] rdata
);

  logic [W-1:0] mem [N_BINS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BINS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  for (genvar k = 0; k < N_BINS; k++) begin : g_rd
    assign rdata[W*k +: W] = mem[k];
  end

endmodule

// File: rtl/fft_frame_packer.sv
// Reorders serial FFT bins into ping-pong banks and
// hands complete frames to the consumer with done/timeout.
module fft_frame_packer
  import fft_pkg::*;
#(
  parameter int BITREV  = 1,
  parameter int TIMEOUT = 64
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic                in_last,
  output logic                fft_valid,
  output logic [N_BINS*W-1:0] data,
  input  logic                done,
  output logic                frame_err,
  output logic                tmo_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [LOG2N-1:0]    cnt;
  logic [LOG2N-1:0]    addr;
  logic                wr_sel;
  logic                rd_sel;
  logic [1:0]          full;
  logic [TW-1:0]       wcnt;
  rd_state_t           state;
  rd_state_t           state_nx;

  logic                beat;
  logic                fin;
  logic                drop;
  logic                rel;
  logic                we0;
  logic                we1;
  logic                set0;
  logic                set1;
  logic                clr0;
  logic                clr1;
  logic [N_BINS*W-1:0] rd0;
  logic [N_BINS*W-1:0] rd1;

  assign in_ready = !full[wr_sel];
  assign beat     = in_valid && in_ready;
  assign fin      = beat &&
                    (cnt == LOG2N'(N_BINS - 1));
  assign drop     = beat && in_last && !fin;

  assign addr = (BITREV != 0) ? bitrev(cnt) : cnt;

  assign we0 = beat && !wr_sel;
  assign we1 = beat &&  wr_sel;

  assign set0 = fin && !wr_sel;
  assign set1 = fin &&  wr_sel;
  assign clr0 = rel && !rd_sel;
  assign clr1 = rel &&  rd_sel;

  fft_bank u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we0),
    .addr  (addr),
    .wdata (in_data),
    .rdata (rd0)
  );

  fft_bank u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we1),
    .addr  (addr),
    .wdata (in_data),
    .rdata (rd1)
  );

  assign data = rd_sel ? rd1 : rd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      wr_sel    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (fin && !in_last) || drop;
      if (fin || drop) begin
        cnt <= '0;
      end else if (beat) begin
        cnt <= cnt + LOG2N'(1);
      end
      if (fin) begin
        wr_sel <= !wr_sel;
      end
    end
  end

  // a bank may be released and the other filled on one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
    end else begin
      full[0] <= (full[0] && !clr0) || set0;
      full[1] <= (full[1] && !clr1) || set1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rd_sel <= 1'b0;
      wcnt   <= '0;
    end else begin
      state <= state_nx;
      if (rel) begin
        rd_sel <= !rd_sel;
      end
      if (state == IDLE) begin
        wcnt <= '0;
      end else begin
        wcnt <= wcnt + TW'(1);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rel       = 1'b0;
    fft_valid = 1'b0;
    tmo_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_sel]) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        fft_valid = 1'b1;
        if (done) begin
          rel      = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          rel      = 1'b1;
          state_nx = IDLE;
        end else if (wcnt == TW'(TIMEOUT)) begin
          rel      = 1'b1;
          tmo_err  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed scoreboard bench for fft_frame_packer.
// Expected frames are queued on send, checked on fft_valid.
module tb_fft_frame_packer;

  localparam int NB  = 16;
  localparam int WW  = 32;
  localparam int DW  = NB * WW;
  localparam int TMO = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          in_last;
  logic          fft_valid;
  logic [DW-1:0] data;
  logic          done;
  logic          frame_err;
  logic          tmo_err;

  fft_frame_packer #(
    .BITREV  (1),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .fft_valid (fft_valid),
    .data      (data),
    .done      (done),
    .frame_err (frame_err),
    .tmo_err   (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int miscomp = 0;
  int cyc = 0;
  int nvalid = 0;
  int vcyc = 0;
  int nferr = 0;
  int ferr_cyc = 0;
  int ntmo = 0;
  int tmo_cyc = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_want;

  function automatic logic [3:0] rev4(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [DW-1:0] frame_of(input int base);
    logic [DW-1:0] f;
    logic [3:0]    k;
    f = '0;
    for (int i = 0; i < NB; i++) begin
      k = rev4(4'(i));
      f[WW*k +: WW] = WW'(base + i);
    end
    return f;
  endfunction

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] want);
    vec++;
    assert (obs === want) else begin
      miscomp++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (fft_valid) begin
      nvalid++;
      vcyc = cyc;
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        last_want = sb.pop_front();
        chk("frame_data", data, last_want);
      end
    end
    if (frame_err) begin
      nferr++;
      ferr_cyc = cyc;
    end
    if (tmo_err) begin
      ntmo++;
      tmo_cyc = cyc;
    end
  endtask

  task automatic send(input int d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = WW'(d);
    in_last  = last;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk("ready_wait", 512'(n < 200), 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int nw,
                            input int last_at,
                            input bit push);
    if (push) sb.push_back(frame_of(base));
    for (int i = 0; i < nw; i++) begin
      send(base + i, i == last_at);
    end
  endtask

  task automatic wait_valid(input int prev);
    int n;
    n = 0;
    while (nvalid == prev && n < 150) begin
      step();
      n++;
    end
    chk("valid_wait", 512'(n < 150), 1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  int lc;
  int pv;
  int pf;
  int pt;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    done = 1'b0;
    last_want = '0;
    repeat (3) step();
    chk("rst_valid", 512'(fft_valid), 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", 512'(frame_err), 0);
    chk("rst_tmo", 512'(tmo_err), 0);
    chk("rst_ready", 512'(in_ready), 1);
    rst = 1'b1;
    step();

    // single frame, bit-reversed placement
    pv = nvalid;
    send_frame(0, 16, 15, 1);
    lc = cyc;
    chk("t1_no_early", 512'(nvalid), 512'(pv));
    wait_valid(pv);
    chk("t1_latency", 512'(vcyc - lc), 1);
    chk("t1_bin1", 512'(data[63:32]), 8);
    chk("t1_bin8", 512'(data[287:256]), 1);
    repeat (4) begin
      step();
      chk("t1_hold", data, last_want);
    end
    pulse_done();
    step();
    chk("t1_one_valid", 512'(nvalid - pv), 1);
    chk("t1_idle_ready", 512'(in_ready), 1);
    chk("t1_no_tmo", 512'(ntmo), 0);

    // back-pressure with three frames
    pv = nvalid;
    send_frame(100, 16, 15, 1);
    send_frame(200, 16, 15, 1);
    step();
    step();
    chk("t2_ready_low", 512'(in_ready), 0);
    chk("t2_one_valid", 512'(nvalid - pv), 1);
    pulse_done();
    lc = cyc;
    chk("t2_ready_back", 512'(in_ready), 1);
    wait_valid(pv + 1);
    chk("t2_issue_lat", 512'(vcyc - lc), 1);
    send_frame(300, 16, 15, 1);
    pulse_done();
    wait_valid(pv + 2);
    pulse_done();
    step();
    chk("t2_three", 512'(nvalid - pv), 3);

    // framing: early in_last drops the frame
    pv = nvalid;
    pf = nferr;
    send_frame(400, 8, 7, 1'b0);
    chk("t3_drop_err", 512'(nferr - pf), 1);
    chk("t3_err_cyc", 512'(ferr_cyc), 512'(cyc));
    repeat (4) step();
    chk("t3_no_valid", 512'(nvalid - pv), 0);
    send_frame(500, 16, 15, 1);
    wait_valid(pv);
    pulse_done();
    chk("t3_no_more_err", 512'(nferr - pf), 1);
    pv = nvalid;
    send_frame(600, 16, -1, 1);
    chk("t3_miss_err", 512'(nferr - pf), 2);
    wait_valid(pv);
    pulse_done();

    // timeout release, queued frame follows
    pv = nvalid;
    pt = ntmo;
    send_frame(700, 16, 15, 1);
    wait_valid(pv);
    lc = vcyc;
    send_frame(800, 16, 15, 1);
    begin
      int n;
      n = 0;
      while (ntmo == pt && n < 120) begin
        step();
        n++;
      end
      chk("t4_tmo_seen", 512'(n < 120), 1);
    end
    chk("t4_tmo_cyc", 512'(tmo_cyc - lc), TMO);
    wait_valid(pv + 1);
    chk("t4_next_lat", 512'(vcyc - tmo_cyc), 2);
    chk("t4_tmo_once", 512'(ntmo - pt), 1);
    pulse_done();

    // reset mid-frame with one bank full
    pv = nvalid;
    send_frame(900, 16, 15, 1);
    wait_valid(pv);
    send_frame(1000, 9, -1, 1'b0);
    rst = 1'b0;
    step();
    step();
    chk("t5_valid", 512'(fft_valid), 0);
    chk("t5_data", data, 0);
    chk("t5_ferr", 512'(frame_err), 0);
    chk("t5_tmo", 512'(tmo_err), 0);
    chk("t5_ready", 512'(in_ready), 1);
    rst = 1'b1;
    step();
    pv = nvalid;
    send_frame(1100, 16, 15, 1);
    wait_valid(pv);
    pulse_done();

    // done on the same edge as the next frame's last beat
    pv = nvalid;
    send_frame(1200, 16, 15, 1);
    wait_valid(pv);
    sb.push_back(frame_of(1300));
    for (int i = 0; i < 15; i++) send(1300 + i, 1'b0);
    done = 1'b1;
    send(1315, 1'b1);
    done = 1'b0;
    lc = cyc;
    chk("t6_ready", 512'(in_ready), 1);
    wait_valid(pv + 1);
    chk("t6_lat", 512'(vcyc - lc), 1);
    pulse_done();
    repeat (3) step();
    chk("sb_drained", 512'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miscomp);
    $finish;
  end

endmodule
